// File: rtl/int_ctrl.sv
// Vectored interrupt controller: per-channel mask/mode/pending registers and a
// three-state request/acknowledge/return handshake with the MCU control unit.
module int_ctrl #(
  parameter int unsigned       NUM_CH    = 8,
  parameter int unsigned       VEC_W     = 10,
  parameter logic [VEC_W-1:0]  VEC_BASE  = 10'h3F0,
  parameter logic [7:0]        MASK_ADDR = 8'hE0,
  parameter logic [7:0]        MODE_ADDR = 8'hE1,
  parameter logic [7:0]        CLR_ADDR  = 8'hE2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_irq,
  input  logic [7:0]        i_port_id,
  input  logic [7:0]        i_out_port,
  input  logic              i_io_strb,
  input  logic              i_int_en_set,
  input  logic              i_int_en_clr,
  input  logic              i_int_ack,
  input  logic              i_int_reti,
  output logic              o_int_req,
  output logic [VEC_W-1:0]  o_int_vec,
  output logic [NUM_CH-1:0] o_pending,
  output logic              o_in_service,
  output logic              o_int_en
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e            r_state;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_irq_prev;
  logic [NUM_CH-1:0] r_pending;
  logic              r_int_en;
  logic [CH_W-1:0]   r_ch;
  logic [VEC_W-1:0]  r_vec;

  state_e            w_state_next;
  logic              w_int_en_next;
  logic [CH_W-1:0]   w_ch_next;
  logic [VEC_W-1:0]  w_vec_next;
  logic [NUM_CH-1:0] w_pending_next;
  logic [NUM_CH-1:0] w_edge;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_ack_vec;
  logic [NUM_CH-1:0] w_active;
  logic [CH_W-1:0]   w_first;
  logic              w_ack;
  logic              w_reti;
  logic              w_wr_mask;
  logic              w_wr_mode;
  logic              w_wr_clr;

  assign w_wr_mask = i_io_strb && (i_port_id == MASK_ADDR);
  assign w_wr_mode = i_io_strb && (i_port_id == MODE_ADDR);
  assign w_wr_clr  = i_io_strb && (i_port_id == CLR_ADDR);
  assign w_ack     = (r_state == StReq) && i_int_ack;
  assign w_reti    = (r_state == StService) && i_int_reti;
  assign w_edge    = i_irq & ~r_irq_prev;
  assign w_clr     = w_wr_clr ? i_out_port[NUM_CH-1:0] : '0;
  assign w_active  = r_pending & r_mask;

  always_comb begin
    w_ack_vec = '0;
    if (w_ack) w_ack_vec[r_ch] = 1'b1;
  end

  // Edge channels: set beats clear. Level channels track the registered source.
  assign w_pending_next = (r_mode & (w_edge | (r_pending & ~w_clr & ~w_ack_vec)))
                        | (~r_mode & i_irq);

  // Scan downwards so the lowest-index active channel is the last assignment.
  always_comb begin
    w_first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_active[i]) w_first = CH_W'(i);
    end
  end

  always_comb begin
    w_int_en_next = r_int_en;
    if (i_int_en_set || w_reti) w_int_en_next = 1'b1;
    if (i_int_en_clr || w_ack)  w_int_en_next = 1'b0;
  end

  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch;
    w_vec_next   = r_vec;
    unique case (r_state)
      StIdle: begin
        if (r_int_en && (|w_active)) begin
          w_ch_next    = w_first;
          w_vec_next   = VEC_BASE + VEC_W'(w_first);
          w_state_next = StReq;
        end
      end
      StReq: begin
        if (i_int_ack)         w_state_next = StService;
        else if (i_int_en_clr) w_state_next = StIdle;
      end
      StService: begin
        if (i_int_reti) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_mask     <= '0;
      r_mode     <= '1;
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_int_en   <= 1'b0;
      r_ch       <= '0;
      r_vec      <= VEC_BASE;
    end else begin
      r_state    <= w_state_next;
      r_irq_prev <= i_irq;
      r_pending  <= w_pending_next;
      r_int_en   <= w_int_en_next;
      r_ch       <= w_ch_next;
      r_vec      <= w_vec_next;
      if (w_wr_mask) r_mask <= i_out_port[NUM_CH-1:0];
      if (w_wr_mode) r_mode <= i_out_port[NUM_CH-1:0];
    end
  end

  assign o_int_req    = (r_state == StReq);
  assign o_in_service = (r_state == StService);
  assign o_int_vec    = r_vec;
  assign o_pending    = r_pending;
  assign o_int_en     = r_int_en;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a per-cycle behavioural model checked on every
// falling edge, plus literal expectations along the handshake scenarios.
module tb_int_ctrl;

  localparam int        NCH   = 8;
  localparam logic [9:0] VBASE = 10'h3F0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq, port_id, out_port;
  logic       strb, sei, cli, ack, reti;
  logic       int_req, in_svc, int_en;
  logic [9:0] vec;
  logic [7:0] pend;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  int_ctrl dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_irq        (irq),
    .i_port_id    (port_id),
    .i_out_port   (out_port),
    .i_io_strb    (strb),
    .i_int_en_set (sei),
    .i_int_en_clr (cli),
    .i_int_ack    (ack),
    .i_int_reti   (reti),
    .o_int_req    (int_req),
    .o_int_vec    (vec),
    .o_pending    (pend),
    .o_in_service (in_svc),
    .o_int_en     (int_en)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_phase 0 = waiting for work, 1 = request posted, 2 = handler running.
  logic [7:0] m_pend, m_mask, m_mode, m_prev;
  logic       m_en;
  int         m_phase, m_ch;
  logic [9:0] m_vec;

  always @(posedge clk) begin : model
    logic [7:0] np;
    int         first, nphase;
    logic       nen;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_mode = '1; m_prev = '0;
      m_en = 1'b0; m_phase = 0; m_ch = 0; m_vec = VBASE;
    end else begin
      first = -1;
      for (int i = NCH - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) first = i;
      for (int i = 0; i < NCH; i++) begin
        if (!m_mode[i])                                  np[i] = irq[i];
        else if (irq[i] && !m_prev[i])                   np[i] = 1'b1;
        else if (strb && port_id == 8'hE2 && out_port[i]) np[i] = 1'b0;
        else if (m_phase == 1 && ack && m_ch == i)       np[i] = 1'b0;
        else                                             np[i] = m_pend[i];
      end
      nphase = m_phase;
      nen    = m_en;
      if (sei) nen = 1'b1;
      case (m_phase)
        0: if (m_en && first >= 0) begin
             nphase = 1; m_ch = first; m_vec = VBASE + 10'(first);
           end
        1: if (ack) nphase = 2; else if (cli) nphase = 0;
        2: if (reti) begin nphase = 0; nen = 1'b1; end
        default: nphase = 0;
      endcase
      if (cli || (m_phase == 1 && ack)) nen = 1'b0;
      if (strb && port_id == 8'hE0) m_mask = out_port;
      if (strb && port_id == 8'hE1) m_mode = out_port;
      m_prev  = irq;
      m_pend  = np;
      m_en    = nen;
      m_phase = nphase;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model int_req",    {31'b0, int_req}, {31'b0, m_phase == 1});
      check("model in_service", {31'b0, in_svc},  {31'b0, m_phase == 2});
      check("model int_en",     {31'b0, int_en},  {31'b0, m_en});
      check("model pending",    {24'b0, pend},    {24'b0, m_pend});
      check("model int_vec",    {22'b0, vec},     {22'b0, m_vec});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; out_port = d; strb = 1'b1;
    tick();
    strb = 1'b0; port_id = '0; out_port = '0;
  endtask

  task automatic pulse_sei();
    sei = 1'b1; tick(); sei = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1; tick(); reti = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " int_req"},    {31'b0, int_req}, 32'd0);
    check({tag, " in_service"}, {31'b0, in_svc},  32'd0);
    check({tag, " int_en"},     {31'b0, int_en},  32'd0);
    check({tag, " pending"},    {24'b0, pend},    32'h00);
    check({tag, " int_vec"},    {22'b0, vec},     32'h3F0);
  endtask

  initial begin
    rst = 1'b1; irq = '0; port_id = '0; out_port = '0;
    strb = 1'b0; sei = 1'b0; cli = 1'b0; ack = 1'b0; reti = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Basic handshake
    wr(8'hE0, 8'h01);
    pulse_sei();
    check("hs int_en", {31'b0, int_en}, 32'd1);
    irq = 8'h01; tick(); irq = '0;
    check("hs pending", {24'b0, pend}, 32'h01);
    check("hs no req yet", {31'b0, int_req}, 32'd0);
    tick();
    check("hs int_req", {31'b0, int_req}, 32'd1);
    check("hs vec", {22'b0, vec}, 32'h3F0);
    do_ack();
    check("hs ack pending", {24'b0, pend}, 32'h00);
    check("hs ack int_en", {31'b0, int_en}, 32'd0);
    check("hs ack in_service", {31'b0, in_svc}, 32'd1);
    do_reti();
    check("hs reti int_en", {31'b0, int_en}, 32'd1);
    check("hs reti in_service", {31'b0, in_svc}, 32'd0);

    // Priority
    wr(8'hE0, 8'hFF);
    irq = 8'h24; tick(); irq = '0;
    check("prio pending", {24'b0, pend}, 32'h24);
    tick();
    check("prio vec first", {22'b0, vec}, 32'h3F2);
    do_ack();
    check("prio pending left", {24'b0, pend}, 32'h20);
    do_reti();
    tick();
    check("prio second req", {31'b0, int_req}, 32'd1);
    check("prio vec second", {22'b0, vec}, 32'h3F5);
    do_ack(); do_reti();

    // Masking and clear
    wr(8'hE0, 8'h00);
    irq = 8'h08; tick(); irq = '0;
    check("mask pending", {24'b0, pend}, 32'h08);
    tick(); tick();
    check("mask no req", {31'b0, int_req}, 32'd0);
    wr(8'hE2, 8'h08);
    check("clr pending", {24'b0, pend}, 32'h00);

    // Set coinciding with ACK clear
    wr(8'hE0, 8'h01);
    irq = 8'h01; tick(); irq = '0; tick();
    check("coinc req", {31'b0, int_req}, 32'd1);
    ack = 1'b1; irq = 8'h01; tick(); ack = 1'b0; irq = '0;
    check("coinc pending kept", {24'b0, pend}, 32'h01);
    check("coinc in_service", {31'b0, in_svc}, 32'd1);
    do_reti(); tick();
    check("coinc reissue", {31'b0, int_req}, 32'd1);
    check("coinc vec", {22'b0, vec}, 32'h3F0);
    do_ack(); do_reti();

    // Level mode
    wr(8'hE1, 8'h00);
    wr(8'hE0, 8'h02);
    irq = 8'h02; tick();
    check("lvl pending", {24'b0, pend}, 32'h02);
    tick();
    check("lvl req", {31'b0, int_req}, 32'd1);
    check("lvl vec", {22'b0, vec}, 32'h3F1);
    do_ack();
    check("lvl pending after ack", {24'b0, pend}, 32'h02);
    do_reti(); tick();
    check("lvl reissue", {31'b0, int_req}, 32'd1);
    do_ack();
    irq = '0; tick();
    check("lvl pending low", {24'b0, pend}, 32'h00);
    do_reti(); tick();
    check("lvl no req", {31'b0, int_req}, 32'd0);

    // Reset in SERVICE, then CLI and reset in REQ
    irq = 8'h02; tick(); tick();
    check("rst setup req", {31'b0, int_req}, 32'd1);
    do_ack();
    check("rst setup service", {31'b0, in_svc}, 32'd1);
    rst = 1'b1; irq = '0; tick(); rst = 1'b0;
    check_reset_vals("rst service");
    pulse_sei();
    wr(8'hE0, 8'h01);
    irq = 8'h01; tick(); irq = '0; tick();
    check("cli setup req", {31'b0, int_req}, 32'd1);
    cli = 1'b1; tick(); cli = 1'b0;
    check("cli drops req", {31'b0, int_req}, 32'd0);
    check("cli keeps pending", {24'b0, pend}, 32'h01);
    pulse_sei(); tick();
    check("cli reissue", {31'b0, int_req}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_vals("rst req");
    pulse_sei();
    irq = 8'h01; tick(); irq = '0;
    check("post rst pending", {24'b0, pend}, 32'h01);
    tick(); tick();
    check("post rst masked", {31'b0, int_req}, 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 8, meaning the number of interrupt channels (legal range 1..8).
REQ-002 The module SHALL have parameter VEC_W, default 10, meaning the vector width, which matches the program-counter width.
REQ-003 The module SHALL have parameter VEC_BASE, default 10'h3F0, meaning the vector of channel 0; VEC_BASE+NUM_CH-1 SHALL NOT exceed 2^VEC_W-1.
REQ-004 The module SHALL have parameters MASK_ADDR (default 8'hE0), MODE_ADDR (default 8'hE1) and CLR_ADDR (default 8'hE2), meaning the port IDs of the control registers.
REQ-005 CLK  input  1  the single system clock; all state updates on the rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 IRQ  input  NUM_CH  interrupt sources, synchronous to CLK.
REQ-008 PORT_ID  input  8  I/O port address from the MCU.
REQ-009 OUT_PORT  input  8  I/O write data from the MCU.
REQ-010 IO_STRB  input  1  I/O write strobe, one cycle wide.
REQ-011 INT_EN_SET / INT_EN_CLR  input  1 each  SEI / CLI from the control unit.
REQ-012 INT_ACK  input  1  the control unit accepts the current request.
REQ-013 INT_RETI  input  1  the control unit has executed RETI.
REQ-014 INT_REQ  output  1  interrupt request to the control unit.
REQ-015 INT_VEC  output  VEC_W  handler address for the PC mux.
REQ-016 PENDING  output  NUM_CH  pending register.
REQ-017 IN_SERVICE  output  1  a handler is executing.
REQ-018 INT_EN  output  1  global interrupt enable.

Function
REQ-019 The module SHALL hold three registers: mask (1 = enabled), mode (1 = edge, 0 = level) and irq_prev.
REQ-020 An edge-mode channel SHALL set its PENDING bit when IRQ[i]=1 and irq_prev[i]=0.
REQ-021 An edge-mode PENDING bit SHALL clear only on an ACK of that channel or on a CLR_ADDR write with bit i set.
REQ-022 When a set condition and a clear condition for the same bit coincide, the set SHALL win.
REQ-023 A level-mode PENDING bit SHALL equal IRQ[i] registered, and ACK/CLR SHALL have no lasting effect on it.
REQ-024 On IO_STRB, PORT_ID==MASK_ADDR SHALL load mask from OUT_PORT[NUM_CH-1:0]; MODE_ADDR SHALL load mode; CLR_ADDR SHALL perform write-1-to-clear of PENDING.
REQ-025 Writes to any other PORT_ID SHALL be ignored.
REQ-026 INT_EN_SET SHALL set INT_EN and INT_EN_CLR SHALL clear it; if both are asserted together, the clear SHALL win.
REQ-027 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-028 In IDLE, if INT_EN=1 and (PENDING & mask) is nonzero, the FSM SHALL latch the lowest-index active channel ch, load INT_VEC=VEC_BASE+ch, and go to REQ.
REQ-029 In REQ, INT_REQ SHALL be 1, and ch and INT_VEC SHALL be held stable even if the source deasserts or is masked.
REQ-030 In REQ, INT_ACK SHALL clear PENDING[ch] (edge mode), clear INT_EN, and move the FSM to SERVICE.
REQ-031 In REQ without INT_ACK, INT_EN_CLR SHALL return the FSM to IDLE with INT_REQ=0 and PENDING unchanged.
REQ-032 In SERVICE, IN_SERVICE SHALL be 1 and INT_REQ SHALL be 0; nesting is not supported.
REQ-033 In SERVICE, INT_RETI SHALL set INT_EN and return the FSM to IDLE.
REQ-034 INT_ACK outside REQ and INT_RETI outside SERVICE SHALL be ignored.
REQ-035 Latency: a rising IRQ sampled at edge k SHALL show in PENDING after edge k; INT_REQ SHALL assert after edge k+1.

Reset
REQ-036 While RESET=1 at a clock edge, the FSM SHALL go to IDLE.
REQ-037 Reset SHALL set INT_REQ=0, IN_SERVICE=0, INT_EN=0, PENDING=0, mask=0, mode=all 1, irq_prev=0 and INT_VEC=VEC_BASE.
REQ-038 Reset SHALL override every other input, including mid-REQ and mid-SERVICE.

Verification
REQ-039 Basic handshake: write mask=8'h01, SEI, pulse IRQ[0] -> PENDING=01 next cycle; INT_REQ=1 and INT_VEC=10'h3F0 one cycle later; ACK -> PENDING=0, INT_EN=0, IN_SERVICE=1; RETI -> INT_EN=1, IDLE.
REQ-040 Priority: mask=8'hFF, IRQ[5] and IRQ[2] rise together -> INT_VEC=10'h3F2; after ACK/RETI, the next request has INT_VEC=10'h3F5.
REQ-041 Masking and clear: IRQ[3] edge with mask=0 -> PENDING[3]=1, no INT_REQ; write CLR_ADDR 8'h08 -> PENDING=0.
REQ-042 Coincident events: a new IRQ[0] edge in the same cycle as the ACK of channel 0 -> PENDING[0] stays 1; the request reissues after RETI.
REQ-043 Level mode: mode=0, IRQ[1] held high through ACK/RETI -> the request reissues; IRQ[1] low -> PENDING[1]=0.
REQ-044 Reset mid-operation: RESET in SERVICE and again in REQ -> all outputs at the REQ-037 values next cycle; a later IRQ with mask=0 does not assert INT_REQ.
